// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between the host and the configuration-chain loader.
// The host drives data/valid; the loader answers with ready.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words LSB-first into a configuration flip-flop chain.
// An optional read-back pass compares the chain tail against a resent stream.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 65,
    parameter int WORD_W    = 8
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 start,
    input  logic                 verify,
    input  logic                 abort,
    ccff_chain_loader_if.slave   cfg,
    output logic                 ccff_head,
    output logic                 ccff_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          mismatch_cnt
);

    localparam int BIT_W = $clog2(CHAIN_LEN + 1);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [BIT_W-1:0] FULL_BITS = BIT_W'(CHAIN_LEN);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    state_t             state_reg, state_next;
    logic               verify_reg;
    logic [WORD_W-1:0]  word_reg;
    logic [CNT_W-1:0]   buf_cnt_reg;
    logic [BIT_W-1:0]   req_cnt_reg;
    logic [BIT_W-1:0]   shift_cnt_reg;
    logic               err_reg;
    logic [15:0]        mis_reg;

    logic               in_pass;
    logic               accept;
    logic               pass_end;
    logic               abort_hit;
    logic               start_hit;
    logic               mismatch;
    logic [BIT_W-1:0]   remaining;
    logic [CNT_W-1:0]   word_bits;

    assign in_pass   = (state_reg == LOAD) || (state_reg == VERIFY);
    assign busy      = in_pass;
    assign done      = (state_reg == DONE);
    assign err       = err_reg;
    assign mismatch_cnt = mis_reg;

    assign ccff_en   = in_pass && (buf_cnt_reg != '0);
    assign ccff_head = ccff_en & word_reg[0];

    // Ready also while the last buffered bit leaves, so words stream without a bubble.
    assign cfg.cfg_ready = in_pass && (req_cnt_reg != FULL_BITS) && (buf_cnt_reg <= CNT_W'(1));
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;

    assign pass_end  = ccff_en && (shift_cnt_reg == LAST_BIT);
    assign abort_hit = abort && in_pass;
    assign start_hit = start && !abort && (state_reg == IDLE);
    assign mismatch  = ccff_en && (state_reg == VERIFY) && (ccff_tail != ccff_head);

    // The final word of a pass only carries the bits still owed to the chain.
    assign remaining = FULL_BITS - req_cnt_reg;
    always_comb begin
        word_bits = CNT_W'(WORD_W);
        if (32'(remaining) < 32'(WORD_W)) begin
            word_bits = CNT_W'(remaining);
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_hit) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (pass_end) begin
                    state_next = verify_reg ? VERIFY : DONE;
                end
            end
            VERIFY: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (pass_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            verify_reg    <= 1'b0;
            word_reg      <= '0;
            buf_cnt_reg   <= '0;
            req_cnt_reg   <= '0;
            shift_cnt_reg <= '0;
            err_reg       <= 1'b0;
            mis_reg       <= '0;
        end else if (abort_hit) begin
            word_reg      <= '0;
            buf_cnt_reg   <= '0;
            req_cnt_reg   <= '0;
            shift_cnt_reg <= '0;
        end else if (start_hit) begin
            verify_reg    <= verify;
            err_reg       <= 1'b0;
            mis_reg       <= '0;
            word_reg      <= '0;
            buf_cnt_reg   <= '0;
            req_cnt_reg   <= '0;
            shift_cnt_reg <= '0;
        end else if (in_pass) begin
            if (accept) begin
                word_reg    <= cfg.cfg_data;
                buf_cnt_reg <= word_bits;
                req_cnt_reg <= req_cnt_reg + BIT_W'(word_bits);
            end else if (ccff_en) begin
                word_reg    <= word_reg >> 1;
                buf_cnt_reg <= buf_cnt_reg - CNT_W'(1);
            end

            // A new pass restarts its request and shift accounting from zero.
            if (pass_end) begin
                req_cnt_reg   <= '0;
                shift_cnt_reg <= '0;
            end else if (ccff_en) begin
                shift_cnt_reg <= shift_cnt_reg + BIT_W'(1);
            end

            if (mismatch) begin
                err_reg <= 1'b1;
                if (mis_reg != 16'hFFFF) begin
                    mis_reg <= mis_reg + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: the driver queues expected head bits and completion results,
// a monitor checks them against the loader while a behavioural chain closes the loop.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 65;
    localparam int WORD_W    = 8;

    logic prog_clk = 1'b0;
    logic pReset   = 1'b0;
    logic start    = 1'b0;
    logic verify   = 1'b0;
    logic abort    = 1'b0;
    logic ccff_head, ccff_en, ccff_tail, busy, done, err;
    logic [15:0] mismatch_cnt;

    ccff_chain_loader_if #(.WORD_W(WORD_W)) bus ();

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .verify       (verify),
        .abort        (abort),
        .cfg          (bus),
        .ccff_head    (ccff_head),
        .ccff_en      (ccff_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mismatch_cnt (mismatch_cnt)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct packed {
        logic        err;
        logic [15:0] cnt;
    } res_t;

    logic [CHAIN_LEN-1:0] chain = '0;
    int   n_shift = 0;
    int   flip_at = -1;
    logic last_en = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   kill  = 1'b0;
    logic exp_bits[$];
    res_t exp_done[$];

    assign ccff_tail = chain[CHAIN_LEN-1];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CHAIN_LEN-1:0] exp_chain(input logic [7:0] w);
        logic [CHAIN_LEN-1:0] r;
        for (int k = 0; k < CHAIN_LEN; k++) begin
            r[CHAIN_LEN-1-k] = w[k % 8];
        end
        return r;
    endfunction

    // Chain of CHAIN_LEN flops; optionally corrupts bit 10 once between passes.
    initial forever begin
        @(posedge prog_clk);
        if (ccff_en) begin
            chain   <= {chain[CHAIN_LEN-2:0], ccff_head};
            n_shift <= n_shift + 1;
        end else if (last_en && n_shift == flip_at) begin
            chain[10] <= ~chain[10];
        end
        last_en <= ccff_en;
    end

    initial begin : monitor
        res_t r;
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge prog_clk);
            if (pReset) begin
                if (ccff_en) begin
                    if (exp_bits.size() == 0) check("extra_shift", ccff_en, 0);
                    else check("head_bit", ccff_head, exp_bits.pop_front());
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        r = exp_done.pop_front();
                        check("done_err", err, r.err);
                        check("done_mismatch_cnt", mismatch_cnt, r.cnt);
                        check("done_bits_left", exp_bits.size(), 0);
                        check("done_after_last_shift", prev_en, 1);
                    end
                end
            end
            prev_en = ccff_en;
        end
    end

    task automatic send_words(input logic [7:0] w, input int nwords, input int period);
        int sent = 0;
        int pushed = 0;
        int cyc = 0;
        int nb;
        logic hs;
        while (sent < nwords && !kill) begin
            bus.cfg_data  = w;
            bus.cfg_valid = ((cyc % period) == 0);
            @(negedge prog_clk);
            hs = bus.cfg_valid && bus.cfg_ready;
            @(posedge prog_clk);
            #1;
            if (hs) begin
                nb = (CHAIN_LEN - pushed < WORD_W) ? CHAIN_LEN - pushed : WORD_W;
                for (int b = 0; b < nb; b++) exp_bits.push_back(w[b]);
                pushed += nb;
                sent++;
            end
            cyc++;
            if (cyc > 2000) begin
                check("send_timeout", sent, nwords);
                break;
            end
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic begin_session(input logic v, output time t0);
        start  = 1'b1;
        verify = v;
        @(posedge prog_clk);
        t0 = $time;
        #1;
        start  = 1'b0;
        verify = 1'b0;
    endtask

    task automatic run_session(input logic [7:0] w, input logic v, input int period,
                               input logic exp_err, input logic [15:0] exp_cnt, output int lat);
        time t0;
        int  base;
        logic got;
        exp_done.push_back('{err: exp_err, cnt: exp_cnt});
        base = n_shift;
        begin_session(v, t0);
        check("busy_after_start", busy, 1);
        send_words(w, 9, period);
        if (v) send_words(w, 9, period);
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge prog_clk);
            if (done) begin
                got = 1'b1;
                lat = int'(($time - t0) / 10);
                break;
            end
        end
        check("done_seen", got, 1);
        @(posedge prog_clk);
        #1;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("shift_total", n_shift - base, v ? 2 * CHAIN_LEN : CHAIN_LEN);
        check("chain_contents", chain, exp_chain(w));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, bus.cfg_ready, 0);
        check({tag, "_head"}, ccff_head, 0);
        check({tag, "_en"}, ccff_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cnt"}, mismatch_cnt, 0);
    endtask

    initial begin : main
        int   lat;
        int   base;
        time  t0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;

        #23;
        check_zero_outputs("reset");
        @(negedge prog_clk);
        pReset = 1'b1;
        @(posedge prog_clk);
        #1;

        // Plain load, continuous valid: 65 contiguous shifts, done right after.
        run_session(8'hA5, 1'b0, 1, 1'b0, 16'd0, lat);
        check("load_latency", lat, 66);

        // Load plus clean verify pass.
        run_session(8'hA5, 1'b1, 1, 1'b0, 16'd0, lat);
        check("verify_latency", lat, 132);

        // Verify with one corrupted chain bit.
        flip_at = n_shift + CHAIN_LEN;
        run_session(8'hA5, 1'b1, 1, 1'b1, 16'd1, lat);
        flip_at = -1;
        check("sticky_err", err, 1);
        check("sticky_cnt", mismatch_cnt, 1);

        // Sparse valid, one cycle in three.
        run_session(8'h3C, 1'b0, 3, 1'b0, 16'd0, lat);

        // Abort after the third word, with a simultaneous start.
        base = n_shift;
        begin_session(1'b0, t0);
        send_words(8'h96, 3, 1);
        abort = 1'b1;
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_en", ccff_en, 0);
        check("abort_done", done, 0);
        check("abort_ready", bus.cfg_ready, 0);
        check("abort_shifts", n_shift - base, 17);
        check("abort_bits_left", exp_bits.size(), 7);
        repeat (5) @(posedge prog_clk);
        #1;
        check("abort_stays_idle", busy, 0);
        exp_bits.delete();

        // Reset in the middle of a load, then a fresh full load.
        base = n_shift;
        begin_session(1'b0, t0);
        fork
            send_words(8'hC3, 9, 1);
            begin
                for (int i = 0; i < 300; i++) begin
                    @(negedge prog_clk);
                    if (n_shift - base >= 30) break;
                end
                check("pre_reset_busy", busy, 1);
                #2;
                pReset = 1'b0;
                #1;
                check_zero_outputs("midreset");
                kill = 1'b1;
            end
        join
        kill = 1'b0;
        bus.cfg_valid = 1'b0;
        exp_bits.delete();
        repeat (2) @(posedge prog_clk);
        #1;
        check("held_reset_busy", busy, 0);
        check("held_reset_en", ccff_en, 0);
        @(negedge prog_clk);
        pReset = 1'b1;
        @(posedge prog_clk);
        #1;
        check("post_reset_idle", busy, 0);
        run_session(8'hC3, 1'b0, 1, 1'b0, 16'd0, lat);
        check("reload_latency", lat, 66);

        repeat (3) @(posedge prog_clk);
        check("done_queue_empty", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 65, number of configuration flip-flops in the downstream chain (64 LUT SRAM bits plus 1 mode bit).
REQ-002 Parameter WORD_W, default 8, width of the bitstream input word.
REQ-003 prog_clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 pReset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a session; honoured only in IDLE.
REQ-006 verify  input  1  sampled with start; 1 = run a VERIFY pass after LOAD.
REQ-007 abort  input  1  terminates any session.
REQ-008 cfg_data  input  WORD_W  bitstream word.
REQ-009 cfg_valid  input  1  cfg_data valid.
REQ-010 cfg_ready  output  1  loader accepts cfg_data this cycle.
REQ-011 ccff_head  output  1  serial data into the head of the chain.
REQ-012 ccff_en  output  1  chain shift enable; the integrator gates prog_clk to the chain with it, so the chain shifts exactly once per cycle with ccff_en=1.
REQ-013 ccff_tail  input  1  serial data from the tail of the chain.
REQ-014 busy  output  1  high in LOAD or VERIFY.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  sticky verify-mismatch flag.
REQ-017 mismatch_cnt  output  16  count of verify mismatches.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, VERIFY and DONE.
REQ-019 IDLE->LOAD on start=1; verify SHALL be latched, and err and mismatch_cnt SHALL be cleared in the same cycle.
REQ-020 LOAD->VERIFY (latched verify=1) or LOAD->DONE (latched verify=0) SHALL occur on the edge that completes the CHAIN_LEN-th shift of LOAD.
REQ-021 VERIFY->DONE SHALL occur on the edge that completes the CHAIN_LEN-th shift of VERIFY.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 abort=1 in LOAD or VERIFY SHALL force IDLE on the next edge, with no done pulse and the word buffer discarded; abort has priority over every other event in the same cycle.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 A word SHALL transfer on the edge where cfg_valid=1 and cfg_ready=1; cfg_data is not sampled otherwise.
REQ-026 cfg_ready SHALL be 1 in LOAD or VERIFY only while unrequested bits remain in the pass, and only when the word buffer is empty or holds its last bit being shifted this cycle; this permits back-to-back words with no bubble.
REQ-027 Serialization SHALL be LSB first: bit 0 of a word is shifted first.
REQ-028 Each buffered bit SHALL drive ccff_head with ccff_en=1 for exactly one cycle, starting the cycle after acceptance.
REQ-029 ccff_en SHALL be 0 whenever the buffer is empty, and in IDLE and DONE.
REQ-030 Each pass (LOAD or VERIFY) SHALL shift exactly CHAIN_LEN bits, using ceil(CHAIN_LEN/WORD_W) words.
REQ-031 Unused upper bits of a pass's final word SHALL be discarded; for the defaults, word 9 uses bit 0 only.
REQ-032 In VERIFY the host resends the identical stream; in every cycle with ccff_en=1, ccff_tail SHALL be compared with ccff_head.
REQ-033 On a VERIFY mismatch, err SHALL be set and mismatch_cnt SHALL increment, saturating at 16'hFFFF.
REQ-034 After a completed VERIFY the chain holds the same contents as after LOAD.
REQ-035 ccff_tail SHALL be ignored outside VERIFY.
REQ-036 Bit and word counters SHALL be sized from ceil(log2(CHAIN_LEN+1)) and ceil(log2(WORD_W+1)) and SHALL never wrap within a pass.

Reset
REQ-037 While pReset=0, asynchronously: state=IDLE; cfg_ready, ccff_head, ccff_en, busy, done and err = 0; mismatch_cnt=0; all counters and the buffer cleared.
REQ-038 Reset mid-session SHALL stop shifting immediately; the chain contents are undefined and a new start is required.
REQ-039 Outputs SHALL leave their reset values only on prog_clk edges after pReset rises.

Verification
REQ-040 Defaults, start with verify=0, 9 words of 8'hA5 with continuous valid -> ccff_en high for exactly 65 cycles with no gaps; ccff_head = 1,0,1,0,0,1,0,1,... ; chain model holds the expected 65 bits; done pulses once, 1 cycle after the last shift.
REQ-041 Same stream with verify=1, chain model of 65 DFFs, stream resent -> 130 shift cycles total, err=0, mismatch_cnt=0, done pulses once.
REQ-042 Verify run with chain-model bit 10 forced to flip after LOAD -> err=1, mismatch_cnt=1, done still pulses.
REQ-043 cfg_valid toggling 1-of-3 cycles -> ccff_en gaps match the input gaps; the bit order is unchanged; exactly 65 shifts.
REQ-044 abort asserted after word 3 is accepted -> next edge: IDLE, busy=0, ccff_en=0, no done; a start in the same cycle as the abort is ignored.
REQ-045 pReset low during LOAD bit 30 -> all outputs zero immediately; after release a fresh start loads the full 65 bits correctly.
